// File: rtl/ir_tx_scheduler.sv
// ir_tx_scheduler: round-robin arbiter that lets N_REQ requesters share one
// byte transmitter. One byte per frame; the winner's byte is latched, a
// one-cycle send_en strobe starts the transmitter, and the frame completes
// when tx_busy falls again. If tx_busy never rises within START_TIMEOUT
// cycles, the frame is abandoned with a tx_err pulse.
//
// Optional feature (compile-time macro IR_TX_GAP_EN):
//   defined   - after each completed frame, wait GAP_CYCLES idle cycles (GAP state)
//   undefined - return to IDLE as soon as tx_busy falls; GAP_CYCLES unused
//
// Ports:
//   CLK_50M   in   system clock, rising edge
//   reset     in   synchronous active-high reset
//   req       in   [N_REQ]   per-requester level request
//   din       in   [8*N_REQ] requester i byte on din[8i+7:8i]
//   tx_busy   in   busy flag from the byte transmitter
//   send_en   out  one-cycle start strobe to the transmitter
//   tx_data   out  [8] byte presented to the transmitter
//   ack       out  [N_REQ] one-hot pulse: requester byte captured
//   done      out  [N_REQ] one-hot pulse: requester frame completed
//   tx_err    out  one-cycle pulse: transmitter failed to start
//   grant_id  out  index of current/last granted requester
//   active    out  high in every state except IDLE
module ir_tx_scheduler #(
    parameter int unsigned N_REQ         = 4,
    parameter int unsigned GAP_CYCLES    = 1900,
    parameter int unsigned START_TIMEOUT = 8
) (
    input  logic                     CLK_50M,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    input  logic [8*N_REQ-1:0]       din,
    input  logic                     tx_busy,
    output logic                     send_en,
    output logic [7:0]               tx_data,
    output logic [N_REQ-1:0]         ack,
    output logic [N_REQ-1:0]         done,
    output logic                     tx_err,
    output logic [$clog2(N_REQ)-1:0] grant_id,
    output logic                     active
);

    localparam int unsigned GW = $clog2(N_REQ);
    localparam int unsigned CW = 16;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ISSUE = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_SEND  = 3'd3;
`ifdef IR_TX_GAP_EN
    localparam logic [2:0] S_GAP   = 3'd4;
`endif

    // Elaboration-time parameter range checks
    if (N_REQ < 2 || N_REQ > 8) begin : g_chk_n_req
        $error("ir_tx_scheduler: N_REQ must be in 2..8");
    end
    if (START_TIMEOUT < 1 || START_TIMEOUT > 65535) begin : g_chk_timeout
        $error("ir_tx_scheduler: START_TIMEOUT must be in 1..65535");
    end
    if (GAP_CYCLES > 65535) begin : g_chk_gap
        $error("ir_tx_scheduler: GAP_CYCLES must fit in 16 bits");
    end
`ifdef IR_TX_GAP_EN
    if (GAP_CYCLES < 1) begin : g_chk_gap_min
        $error("ir_tx_scheduler: GAP_CYCLES must be at least 1");
    end
`endif

    logic [2:0]       state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [GW-1:0]    last_grant, last_nxt;
    logic [GW-1:0]    grant_nxt;
    logic [7:0]       tx_data_nxt;
    logic             send_en_nxt;
    logic [N_REQ-1:0] ack_nxt;
    logic [N_REQ-1:0] done_nxt;
    logic             tx_err_nxt;
    logic             win_found;
    logic [GW-1:0]    win_id;

    // Round-robin pick: first requester at or after last_grant+1 (mod N_REQ)
    always_comb begin : rr_pick
        logic [GW-1:0] cand;
        cand      = '0;
        win_found = 1'b0;
        win_id    = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            cand = GW'((32'(last_grant) + i + 32'd1) % N_REQ);
            if (!win_found && req[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        send_en_nxt = 1'b0;
        ack_nxt     = '0;
        done_nxt    = '0;
        tx_err_nxt  = 1'b0;
        tx_data_nxt = tx_data;
        grant_nxt   = grant_id;
        last_nxt    = last_grant;

        case (state)
            S_IDLE: begin
                if (win_found) begin
                    state_nxt   = S_ISSUE;
                    send_en_nxt = 1'b1;
                    ack_nxt     = N_REQ'(1) << win_id;
                    tx_data_nxt = din[32'(win_id)*8 +: 8];
                    grant_nxt   = win_id;
                end
            end
            S_ISSUE: begin
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (tx_busy) begin
                    state_nxt = S_SEND;
                end else if (cnt >= CW'(START_TIMEOUT - 1)) begin
                    // Transmitter never started: abandon frame, no gap
                    tx_err_nxt = 1'b1;
                    last_nxt   = grant_id;
                    state_nxt  = S_IDLE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            S_SEND: begin
                if (!tx_busy) begin
                    done_nxt = N_REQ'(1) << grant_id;
                    last_nxt = grant_id;
`ifdef IR_TX_GAP_EN
                    state_nxt = S_GAP;
`else
                    state_nxt = S_IDLE;
`endif
                end
            end
`ifdef IR_TX_GAP_EN
            S_GAP: begin
                if (cnt >= CW'(GAP_CYCLES - 1)) begin
                    state_nxt = S_IDLE;
                end else if (cnt != '1) begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
`endif
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        // Counter restarts from zero on every state entry
        if (state_nxt != state) begin
            cnt_nxt = '0;
        end
    end

    // State and output registers
    always_ff @(posedge CLK_50M) begin
        if (reset) begin
            state      <= S_IDLE;
            cnt        <= '0;
            last_grant <= GW'(N_REQ - 1);
            send_en    <= 1'b0;
            tx_data    <= '0;
            ack        <= '0;
            done       <= '0;
            tx_err     <= 1'b0;
            grant_id   <= '0;
            active     <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_nxt;
            send_en    <= send_en_nxt;
            tx_data    <= tx_data_nxt;
            ack        <= ack_nxt;
            done       <= done_nxt;
            tx_err     <= tx_err_nxt;
            grant_id   <= grant_nxt;
            active     <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_ir_tx_scheduler.sv
// Testbench for ir_tx_scheduler: scoreboard of expected grants, a simple
// byte-transmitter model, and one task per scenario.
module tb_ir_tx_scheduler;

    localparam int unsigned NR  = 4;
    localparam int unsigned GAP = 40;
    localparam int unsigned TO  = 8;
`ifdef IR_TX_GAP_EN
    localparam int GAP_EFF = GAP;
`else
    localparam int GAP_EFF = 0;
`endif

    logic            CLK_50M;
    logic            reset;
    logic [NR-1:0]   req;
    logic [8*NR-1:0] din;
    logic            tx_busy;
    logic            send_en;
    logic [7:0]      tx_data;
    logic [NR-1:0]   ack;
    logic [NR-1:0]   done;
    logic            tx_err;
    logic [1:0]      grant_id;
    logic            active;

    ir_tx_scheduler #(
        .N_REQ(NR),
        .GAP_CYCLES(GAP),
        .START_TIMEOUT(TO)
    ) dut (
        .CLK_50M (CLK_50M),
        .reset   (reset),
        .req     (req),
        .din     (din),
        .tx_busy (tx_busy),
        .send_en (send_en),
        .tx_data (tx_data),
        .ack     (ack),
        .done    (done),
        .tx_err  (tx_err),
        .grant_id(grant_id),
        .active  (active)
    );

    typedef struct packed {
        logic [1:0] id;
        logic [7:0] data;
        logic       err;
    } exp_t;

    exp_t sb[$];
    bit   sb_acked    = 1'b0;
    bit   never_busy  = 1'b0;
    bit   measure_gap = 1'b0;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   ack_cyc   = 0;
    int   fall_cyc  = 0;
    int   fall_n    = 0;
    int   gap_ref_n = 0;
    int   bcnt      = 0;

    initial CLK_50M = 1'b0;
    always #10 CLK_50M = ~CLK_50M;

    always @(posedge CLK_50M) cyc <= cyc + 1;

    // Transmitter model: busy for 20 cycles after each send_en
    initial begin
        tx_busy = 1'b0;
        forever begin
            @(posedge CLK_50M);
            #1;
            if (reset) begin
                tx_busy = 1'b0;
                bcnt    = 0;
            end else if (send_en && !never_busy) begin
                tx_busy = 1'b1;
                bcnt    = 20;
            end else if (bcnt > 0) begin
                bcnt = bcnt - 1;
                if (bcnt == 0) begin
                    tx_busy  = 1'b0;
                    fall_cyc = cyc;
                    fall_n   = fall_n + 1;
                end
            end
        end
    end

    function automatic logic [NR-1:0] oh(input logic [1:0] i);
        logic [NR-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    function automatic exp_t mk(input logic [1:0] id, input logic [7:0] data, input logic err);
        exp_t e;
        e.id   = id;
        e.data = data;
        e.err  = err;
        return e;
    endfunction

    // Advance one cycle and check ack/done/tx_err events against the scoreboard
    task automatic step();
        exp_t e;
        @(negedge CLK_50M);
        if (ack !== '0) begin
            total++;
            if (sb.size() == 0 || sb_acked) begin
                bad++;
                $display("FAIL extra_ack: ack=%b with no pending grant at cycle %0d", ack, cyc);
            end else begin
                e = sb[0];
                if (ack !== oh(e.id) || send_en !== 1'b1 || tx_data !== e.data || grant_id !== e.id) begin
                    bad++;
                    $display("FAIL grant: got ack=%b send_en=%b tx_data=%h grant_id=%0d, want ack=%b send_en=1 tx_data=%h grant_id=%0d",
                             ack, send_en, tx_data, grant_id, oh(e.id), e.data, e.id);
                end
                sb_acked = 1'b1;
                ack_cyc  = cyc;
                if (measure_gap && fall_n != gap_ref_n) begin
                    total++;
                    if (cyc - fall_cyc != GAP_EFF + 2) begin
                        bad++;
                        $display("FAIL gap_spacing: send_en %0d cycles after tx_busy fall, want %0d",
                                 cyc - fall_cyc, GAP_EFF + 2);
                    end
                    gap_ref_n = fall_n;
                end
            end
        end else if (send_en !== 1'b0) begin
            total++;
            bad++;
            $display("FAIL send_en_alone: send_en=%b with ack=%b", send_en, ack);
        end
        if (done !== '0) begin
            total++;
            if (sb.size() == 0 || !sb_acked) begin
                bad++;
                $display("FAIL unexpected_done: done=%b, want none", done);
            end else begin
                e        = sb.pop_front();
                sb_acked = 1'b0;
                if (e.err || done !== oh(e.id) || tx_err !== 1'b0) begin
                    bad++;
                    $display("FAIL done: got done=%b tx_err=%b, want done=%b err_frame=%b",
                             done, tx_err, oh(e.id), e.err);
                end
            end
        end
        if (tx_err !== 1'b0) begin
            total++;
            if (sb.size() == 0 || !sb_acked) begin
                bad++;
                $display("FAIL unexpected_tx_err: tx_err=%b, want 0", tx_err);
            end else begin
                e        = sb.pop_front();
                sb_acked = 1'b0;
                if (!e.err || cyc - ack_cyc != int'(TO) + 1) begin
                    bad++;
                    $display("FAIL tx_err: got err %0d cycles after ack (err_frame=%b), want %0d with err_frame=1",
                             cyc - ack_cyc, e.err, TO + 1);
                end
            end
        end
    endtask

    // Run until the scoreboard empties; drop req once the last grant is acked
    task automatic drain(input int budget, output int left);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            step();
            n++;
            if (sb.size() == 1 && sb_acked) req = '0;
        end
        left = sb.size();
        sb.delete();
        sb_acked = 1'b0;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1;
        sb.delete();
        sb_acked = 1'b0;
        repeat (n) step();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) step();
        total++; if (send_en !== 1'b0)  begin bad++; $display("FAIL rst_send_en: got %b want 0", send_en); end
        total++; if (ack !== '0)        begin bad++; $display("FAIL rst_ack: got %b want 0000", ack); end
        total++; if (done !== '0)       begin bad++; $display("FAIL rst_done: got %b want 0000", done); end
        total++; if (tx_err !== 1'b0)   begin bad++; $display("FAIL rst_tx_err: got %b want 0", tx_err); end
        total++; if (active !== 1'b0)   begin bad++; $display("FAIL rst_active: got %b want 0", active); end
        total++; if (tx_data !== 8'h00) begin bad++; $display("FAIL rst_tx_data: got %h want 00", tx_data); end
        total++; if (grant_id !== 2'd0) begin bad++; $display("FAIL rst_grant_id: got %0d want 0", grant_id); end
        reset = 1'b0;
    endtask

    task automatic test_basic();
        int left;
        din = 32'h0000_00A5;
        req = 4'b0001;
        sb.push_back(mk(2'd0, 8'hA5, 1'b0));
        step();
        total++; if (send_en !== 1'b1)   begin bad++; $display("FAIL basic_send_en: got %b want 1", send_en); end
        total++; if (ack !== 4'b0001)    begin bad++; $display("FAIL basic_ack: got %b want 0001", ack); end
        total++; if (tx_data !== 8'hA5)  begin bad++; $display("FAIL basic_tx_data: got %h want a5", tx_data); end
        total++; if (active !== 1'b1)    begin bad++; $display("FAIL basic_active: got %b want 1", active); end
        req = '0;
        step();
        total++; if (send_en !== 1'b0)   begin bad++; $display("FAIL basic_pulse: send_en got %b want 0", send_en); end
        total++; if (ack !== '0)         begin bad++; $display("FAIL basic_ack_pulse: got %b want 0000", ack); end
        drain(200, left);
        total++; if (left != 0) begin bad++; $display("FAIL basic_drain: %0d frames pending, want 0", left); end
    endtask

    task automatic test_round_robin();
        int left;
        do_reset(2);
        din = 32'h4433_2211;
        req = 4'b1111;
        gap_ref_n   = fall_n;
        measure_gap = 1'b1;
        sb.push_back(mk(2'd0, 8'h11, 1'b0));
        sb.push_back(mk(2'd1, 8'h22, 1'b0));
        sb.push_back(mk(2'd2, 8'h33, 1'b0));
        sb.push_back(mk(2'd3, 8'h44, 1'b0));
        sb.push_back(mk(2'd0, 8'h11, 1'b0));
        drain(800, left);
        measure_gap = 1'b0;
        total++; if (left != 0) begin bad++; $display("FAIL rr_drain: %0d frames pending, want 0", left); end
    endtask

    task automatic test_timeout();
        int left;
        never_busy = 1'b1;
        din = 32'hC3B2_5A96;
        req = 4'b0010;
        sb.push_back(mk(2'd1, 8'h5A, 1'b1));
        drain(100, left);
        total++; if (left != 0) begin bad++; $display("FAIL timeout_drain: %0d frames pending, want 0", left); end
        never_busy = 1'b0;
        // last_grant is now 1, so requester 0 wins over 1
        req = 4'b0011;
        sb.push_back(mk(2'd0, 8'h96, 1'b0));
        drain(200, left);
        total++; if (left != 0) begin bad++; $display("FAIL after_timeout_drain: %0d frames pending, want 0", left); end
    endtask

    task automatic test_hold_during_send();
        int left;
        int n;
        din = 32'h1122_3C44;
        req = 4'b0010;
        sb.push_back(mk(2'd1, 8'h3C, 1'b0));
        n = 0;
        while (!sb_acked && n < 10) begin step(); n++; end
        total++; if (!sb_acked) begin bad++; $display("FAIL hold_ack: no ack within 10 cycles, want ack"); end
        req = '0;
        repeat (3) step();
        for (int i = 0; i < 8; i++) begin
            req = 4'($urandom);
            din = $urandom;
            step();
            total++;
            if (tx_data !== 8'h3C || grant_id !== 2'd1 || active !== 1'b1) begin
                bad++;
                $display("FAIL hold_stable: tx_data=%h grant_id=%0d active=%b, want 3c 1 1", tx_data, grant_id, active);
            end
        end
        req = '0;
        drain(100, left);
        total++; if (left != 0) begin bad++; $display("FAIL hold_drain: %0d frames pending, want 0", left); end
    endtask

    task automatic test_reset_mid_send();
        int left;
        int n;
        din = 32'h0000_00E7;
        req = 4'b0001;
        sb.push_back(mk(2'd0, 8'hE7, 1'b0));
        n = 0;
        while (!sb_acked && n < 10) begin step(); n++; end
        req = '0;
        repeat (5) step();
        total++;
        if (active !== 1'b1 || tx_busy !== 1'b1) begin
            bad++;
            $display("FAIL mid_send_setup: active=%b tx_busy=%b, want 1 1", active, tx_busy);
        end
        reset = 1'b1;
        sb.delete();
        sb_acked = 1'b0;
        step();
        total++;
        if (send_en !== 1'b0 || ack !== '0 || done !== '0 || tx_err !== 1'b0 ||
            active !== 1'b0 || tx_data !== 8'h00 || grant_id !== 2'd0) begin
            bad++;
            $display("FAIL mid_send_reset: send_en=%b ack=%b done=%b tx_err=%b active=%b tx_data=%h grant_id=%0d, want all zero",
                     send_en, ack, done, tx_err, active, tx_data, grant_id);
        end
        reset = 1'b0;
        repeat (25) step();
        din = 32'h00D4_0000;
        req = 4'b0100;
        sb.push_back(mk(2'd2, 8'hD4, 1'b0));
        sb.push_back(mk(2'd2, 8'hD4, 1'b0));
        drain(300, left);
        total++; if (left != 0) begin bad++; $display("FAIL post_reset_drain: %0d frames pending, want 0", left); end
    endtask

    initial begin
        reset = 1'b1;
        req   = '0;
        din   = '0;
        test_reset();
        test_basic();
        test_round_robin();
        test_timeout();
        test_hold_during_send();
        test_reset_mid_send();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
